bus_source_arbiter: RTL and testbench
=====================================

// Module: bus_source_arbiter
// PURPOSE
//   Round-robin arbiter that shares the processor's 8-bit internal bus between up to five sources.
//   Drives the 3-bit select of the 5:1 8-bit bus mux, one source at a time.
//   Issues a registered one-hot grant. Forces one dead (idle-select) cycle between owners.
//   Bounds ownership with a hold timeout. Sits between the requesting units and the bus mux select.
// PARAMETERS
//   N_REQ     5    number of requesters; must be <= 2**SEL_W - 1
//   SEL_W     3    width of bus_sel
//   MAX_HOLD  16   max consecutive grant cycles per ownership; must be >= 2
//   HOLD_W    5    hold counter width; 2**HOLD_W > MAX_HOLD
//   IDLE_SEL  7    bus_sel value when no owner; must be >= N_REQ, so the mux default drives 8'h00
// PORTS
//   clock        in   1       rising-edge clock
//   reset_n      in   1       async active-low reset
//   req          in   N_REQ   level request per source; held while ownership wanted
//   gnt          out  N_REQ   registered one-hot grant; all-zero when no owner
//   bus_sel      out  SEL_W   registered select to bus mux: owner index, else IDLE_SEL
//   bus_busy     out  1       high while state==GRANT
//   hold_timeout out  1       one-cycle pulse: previous ownership ended by timeout
// BEHAVIOUR
//   - Reset (async, immediate, no clock needed):
//     - state=IDLE, gnt=0, bus_sel=IDLE_SEL, bus_busy=0, hold_timeout=0.
//     - rr_ptr=0, hold_cnt=0.
//   - States: IDLE, GRANT, TURN. All outputs are registered and change only on clock edges.
//   - Arbitration (in IDLE and TURN):
//     - Winner = first set req bit searching rr_ptr, rr_ptr+1, ... with wrap at N_REQ-1 -> 0.
//     - If any req is set: next state GRANT; gnt=onehot(winner); bus_sel=winner; hold_cnt=0.
//     - Latency is 1 cycle from req sampled to gnt high.
//     - If no req is set: next state IDLE with outputs at idle values.
//   - GRANT:
//     - hold_cnt increments each cycle.
//     - Release when req[owner]==0, or when hold_cnt==MAX_HOLD-1, i.e. owner has held MAX_HOLD cycles.
//     - On release: next state TURN; gnt=0; bus_sel=IDLE_SEL; rr_ptr=(owner+1) mod N_REQ.
//     - hold_timeout=1 during the TURN cycle only if the release was a timeout; otherwise 0.
//   - TURN: exactly one dead cycle on the bus, then arbitration as in IDLE.
//     - Back-to-back ownership is therefore GRANT..GRANT, TURN, GRANT.
//   - A timed-out requester that keeps req high re-competes normally.
//     - It is granted again only if no other requester is found first after rr_ptr.
//   - If req[owner] drops in the same cycle that hold_cnt hits its limit, the release is a normal release: hold_timeout=0.
//   - req bits of non-owners are not latched. A pulse that drops before arbitration samples it is lost.
//   - Changes to non-owner req bits during GRANT have no effect on the current grant.
//   - gnt is never multi-hot. bus_sel is always either a valid index matching gnt, or IDLE_SEL.
//   - Reset asserted mid-grant clears all outputs immediately; the next grant starts a fresh search from rr_ptr=0.
// STRUCTURE
//   - Shared header bus_arb_defs.vh holds:
//     - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_TURN=2'd2.
//     - default IDLE_SEL.
//   - One combinational sub-module rr_priority_pick (N_REQ, SEL_W):
//     - inputs req and rr_ptr; outputs any_req and win_idx.
//     - implements the rotate, priority-encode and unrotate steps.
//   - Top level keeps the FSM, hold counter, rr_ptr and output registers.
// TESTING
//   1. Reset: reset_n=0 with req=5'b11111.
//      - gnt=0, bus_sel=7, bus_busy=0.
//      - After reset_n=1, the first edge gives gnt=5'b00001, bus_sel=0.
//   2. Single source: req=5'b00100 for 3 grant cycles, then 0.
//      - gnt=00100 and bus_sel=2 for 3 cycles starting 1 cycle after req.
//      - Then bus_sel=7 and gnt=0, with bus_busy low.
//   3. Round robin: req=5'b10011 kept high; each owner drops its req after 2 grant cycles and reasserts in TURN.
//      - Grant order 0, 1, 4, 0, each ownership separated by one cycle with bus_sel=7.
//   4. Timeout (MAX_HOLD=4): req=5'b01000 held constant.
//      - gnt=01000 for exactly 4 cycles.
//      - TURN cycle with hold_timeout=1.
//      - Then re-granted to 3.
//   5. Wrap: after owner 3 releases (rr_ptr=4), req=5'b00101.
//      - Grants 0 first, then 2 (rr_ptr=1 after owner 0).
//   6. Async reset mid-grant: drop reset_n between clock edges while gnt=00010.
//      - gnt=0 and bus_sel=7 immediately, with no clock edge.
//      - With req=5'b00010 still set after release, the next grant is to 1 from rr_ptr=0.

Source files
------------

// File: rtl/bus_source_arbiter_pkg.sv
// Shared state encoding and default idle select for the bus source arbiter.
// Latency: none; declarations only.
// Backpressure: not applicable.
package bus_source_arbiter_pkg;

  // Arbiter FSM states; TURN is the single dead cycle between two owners
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  // Mux select that matches no source, so the 5:1 mux default drives 8'h00
  localparam int DEF_IDLE_SEL = 7;

endpackage

// File: rtl/bus_source_arbiter_pick.sv
// Round-robin winner search: rotate req by rr_ptr, priority-encode, unrotate.
// Latency: purely combinational.
// Backpressure: none; reports any_req so the caller can decide to idle.
module rr_priority_pick #(
  parameter int N_REQ = 5,
  parameter int SEL_W = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic             any_req,
  output logic [SEL_W-1:0] win_idx
);

  localparam logic [SEL_W-1:0] NQ   = SEL_W'(N_REQ);
  localparam logic [SEL_W:0]   NQ_W = (SEL_W+1)'(N_REQ);

  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] first;
  logic [SEL_W-1:0] acc [N_REQ+1];
  logic [SEL_W:0]   sum;

  // Rotate so that position 0 of rot corresponds to req[rr_ptr]
  assign rot = (req >> rr_ptr) | (req << (NQ - rr_ptr));

  // Isolate the lowest set bit of the rotated vector
  assign first = rot & (-rot);

  // One-hot to binary position, built as an OR chain over the bits
  assign acc[0] = '0;
  for (genvar g = 0; g < N_REQ; g++) begin : g_enc
    assign acc[g+1] = acc[g] | (first[g] ? SEL_W'(g) : '0);
  end

  // Unrotate: add rr_ptr back and wrap modulo N_REQ
  assign sum     = {1'b0, acc[N_REQ]} + {1'b0, rr_ptr};
  assign win_idx = (sum >= NQ_W) ? SEL_W'(sum - NQ_W) : SEL_W'(sum);
  assign any_req = |req;

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin owner of the shared 8-bit internal bus; drives one-hot grant and mux select.
// Latency: 1 cycle from req sampled to gnt; one idle-select cycle between successive owners.
// Backpressure: owner keeps the bus while req holds, capped at MAX_HOLD cycles by a timeout.
module bus_source_arbiter
  import bus_source_arbiter_pkg::*;
#(
  parameter int N_REQ    = 5,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5,
  parameter int IDLE_SEL = DEF_IDLE_SEL
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] bus_sel,
  output logic             bus_busy,
  output logic             hold_timeout
);

  localparam logic [SEL_W-1:0]  SEL_IDLE = SEL_W'(IDLE_SEL);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  arb_state_t       state, nxt_state;
  logic [SEL_W-1:0] rr_ptr, nxt_ptr;
  logic [HOLD_W-1:0] hold_cnt, nxt_cnt;
  logic [N_REQ-1:0] nxt_gnt;
  logic [SEL_W-1:0] nxt_sel;
  logic             nxt_timeout;

  logic             any_req;
  logic [SEL_W-1:0] win_idx;
  logic             owner_req;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .any_req (any_req),
    .win_idx (win_idx)
  );

  // The owner's own request; gnt is one-hot so masking avoids an indexed select
  assign owner_req = |(req & gnt);
  assign bus_busy  = (state == ST_GRANT);

  // Next-state, grant and select decode for the three-state ownership cycle
  always_comb begin
    nxt_state   = state;
    nxt_gnt     = gnt;
    nxt_sel     = bus_sel;
    nxt_ptr     = rr_ptr;
    nxt_cnt     = hold_cnt;
    nxt_timeout = 1'b0;
    case (state)
      ST_IDLE, ST_TURN: begin
        nxt_cnt = '0;
        if (any_req) begin
          nxt_state = ST_GRANT;
          nxt_gnt   = N_REQ'(1) << win_idx;
          nxt_sel   = win_idx;
        end else begin
          nxt_state = ST_IDLE;
          nxt_gnt   = '0;
          nxt_sel   = SEL_IDLE;
        end
      end
      ST_GRANT: begin
        if (!owner_req || hold_cnt == HOLD_LIM) begin
          // A still-requesting owner here can only be leaving by timeout
          nxt_state   = ST_TURN;
          nxt_gnt     = '0;
          nxt_sel     = SEL_IDLE;
          nxt_ptr     = (bus_sel == SEL_LAST) ? '0 : bus_sel + SEL_W'(1);
          nxt_cnt     = '0;
          nxt_timeout = owner_req;
        end else begin
          nxt_cnt = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_gnt   = '0;
        nxt_sel   = SEL_IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // State, pointer, counter and output registers with immediate async clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      gnt          <= '0;
      bus_sel      <= SEL_IDLE;
      hold_timeout <= 1'b0;
      rr_ptr       <= '0;
      hold_cnt     <= '0;
    end else begin
      state        <= nxt_state;
      gnt          <= nxt_gnt;
      bus_sel      <= nxt_sel;
      hold_timeout <= nxt_timeout;
      rr_ptr       <= nxt_ptr;
      hold_cnt     <= nxt_cnt;
    end
  end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Self-checking bench for bus_source_arbiter against a cycle-level ownership model.
// Latency: outputs checked 1 time unit after each rising clock edge.
// Backpressure: not applicable.
module tb_bus_source_arbiter;

  localparam int N    = 5;
  localparam int MAXH = 4;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic [4:0] req     = '0;
  logic [4:0] gnt;
  logic [2:0] bus_sel;
  logic       bus_busy;
  logic       hold_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the bus, for how many cycles, where the search starts
  int m_owner;
  int m_held;
  int m_ptr;
  bit m_to;

  bus_source_arbiter #(
    .N_REQ    (N),
    .SEL_W    (3),
    .MAX_HOLD (MAXH),
    .HOLD_W   (5),
    .IDLE_SEL (7)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req          (req),
    .gnt          (gnt),
    .bus_sel      (bus_sel),
    .bus_busy     (bus_busy),
    .hold_timeout (hold_timeout)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_to    = 1'b0;
  endtask

  // One clock of the model: owner keeps the bus, gives it up, or a new owner is picked
  task automatic model_step(input logic [4:0] r);
    bit own;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      own = ((r >> m_owner) & 5'd1) != 5'd0;
      if (!own || m_held == MAXH) begin
        m_to    = own;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_owner < 0 && ((r >> idx) & 5'd1) != 5'd0) begin
          m_owner = idx;
          m_held  = 1;
        end
      end
    end
  endtask

  function automatic logic [9:0] model_vec();
    logic [4:0] g;
    logic [2:0] s;
    g = '0;
    s = 3'd7;
    if (m_owner >= 0) begin
      g = 5'd1 << m_owner;
      s = 3'(m_owner);
    end
    return {g, s, (m_owner >= 0), m_to};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {gnt, bus_sel, bus_busy, hold_timeout};
  endfunction

  task automatic step(input logic [4:0] r);
    req = r;
    @(posedge clock);
    model_step(r);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 5'b11111;
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (gnt !== 5'b0 || bus_sel !== 3'd7 || bus_busy !== 1'b0 || hold_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: got gnt=%b sel=%0d busy=%b to=%b, want 00000/7/0/0", gnt, bus_sel, bus_busy, hold_timeout);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (gnt !== 5'b0 || bus_sel !== 3'd7) begin
      n_bad++;
      $display("FAIL reset_held: got gnt=%b sel=%0d, want 00000/7", gnt, bus_sel);
    end
    @(negedge clock);
    reset_n = 1'b1;
    step(5'b11111);
    n_cmp++;
    if (gnt !== 5'b00001 || bus_sel !== 3'd0 || bus_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_first_grant: got gnt=%b sel=%0d, want 00001/0", gnt, bus_sel);
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(5'b00100);
      n_cmp++;
      if (gnt !== 5'b00100 || bus_sel !== 3'd2 || dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL single_grant[%0d]: got %b, want gnt=00100 sel=2 (%b)", i, dut_vec(), model_vec());
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(5'b00000);
      n_cmp++;
      if (gnt !== 5'b0 || bus_sel !== 3'd7 || bus_busy !== 1'b0 || dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL single_release[%0d]: got %b, want %b", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 1, 4, 0};
    logic [4:0] oh;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      oh = 5'd1 << order[k];
      step(5'b10011);
      n_cmp++;
      if (gnt !== oh || bus_sel !== 3'(order[k]) || dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: got gnt=%b sel=%0d, want gnt=%b sel=%0d", k, gnt, bus_sel, oh, order[k]);
      end
      step(5'b10011);
      n_cmp++;
      if (gnt !== oh || dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL rr_hold[%0d]: got %b, want %b", k, dut_vec(), model_vec());
      end
      step(5'b10011 & ~oh);
      n_cmp++;
      if (gnt !== 5'b0 || bus_sel !== 3'd7 || hold_timeout !== 1'b0 || dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL rr_turn[%0d]: got %b, want %b", k, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < MAXH; i++) begin
      step(5'b01000);
      n_cmp++;
      if (gnt !== 5'b01000 || hold_timeout !== 1'b0 || dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL timeout_hold[%0d]: got %b, want %b", i, dut_vec(), model_vec());
      end
    end
    step(5'b01000);
    n_cmp++;
    if (gnt !== 5'b0 || bus_sel !== 3'd7 || hold_timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_turn: got gnt=%b sel=%0d to=%b, want 00000/7/1", gnt, bus_sel, hold_timeout);
    end
    step(5'b01000);
    n_cmp++;
    if (gnt !== 5'b01000 || bus_sel !== 3'd3 || hold_timeout !== 1'b0 || dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL timeout_regrant: got %b, want %b", dut_vec(), model_vec());
    end
  endtask

  task automatic test_wrap();
    step(5'b00101);
    n_cmp++;
    if (gnt !== 5'b0 || hold_timeout !== 1'b0 || dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL wrap_release3: got %b, want %b", dut_vec(), model_vec());
    end
    step(5'b00101);
    n_cmp++;
    if (gnt !== 5'b00001 || bus_sel !== 3'd0) begin
      n_bad++;
      $display("FAIL wrap_first: got gnt=%b sel=%0d, want 00001/0", gnt, bus_sel);
    end
    step(5'b00100);
    step(5'b00101);
    n_cmp++;
    if (gnt !== 5'b00100 || bus_sel !== 3'd2 || dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL wrap_second: got gnt=%b sel=%0d, want 00100/2", gnt, bus_sel);
    end
  endtask

  task automatic test_limit_drop();
    do_reset();
    for (int i = 0; i < MAXH; i++) step(5'b00010);
    step(5'b00000);
    n_cmp++;
    if (gnt !== 5'b0 || hold_timeout !== 1'b0 || dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL limit_drop: got to=%b gnt=%b, want to=0 gnt=00000", hold_timeout, gnt);
    end
  endtask

  task automatic test_async_mid_grant();
    do_reset();
    step(5'b01010);
    step(5'b00010);
    step(5'b00010);
    n_cmp++;
    if (gnt !== 5'b00010 || dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL async_pre: got %b, want %b", dut_vec(), model_vec());
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (gnt !== 5'b0 || bus_sel !== 3'd7 || bus_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_clear: got gnt=%b sel=%0d busy=%b, want 00000/7/0", gnt, bus_sel, bus_busy);
    end
    @(negedge clock);
    reset_n = 1'b1;
    step(5'b00010);
    n_cmp++;
    if (gnt !== 5'b00010 || bus_sel !== 3'd1 || dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL async_regrant: got gnt=%b sel=%0d, want 00010/1", gnt, bus_sel);
    end
    step(5'b00011);
    step(5'b00011);
    n_cmp++;
    if (dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL async_ptr_fresh: got %b, want %b", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    logic [4:0] r;
    r = '0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) r = 5'($urandom);
      step(r);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL rand_cycle %0d: req=%b got %b, want %b", c, r, dut_vec(), model_vec());
      end
      n_cmp++;
      if ($countones(gnt) > 1 || ((gnt == 5'b0) != (bus_sel == 3'd7))) begin
        n_bad++;
        $display("FAIL rand_onehot %0d: got gnt=%b sel=%0d, want one-hot gnt consistent with sel", c, gnt, bus_sel);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_wrap();
    test_limit_drop();
    test_async_mid_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
